// File: rtl/rx_string_pkg.sv
// Shared definitions for the string receive/transmit pair: FSM states and
// the special byte values that frame a stored string.
package rx_string_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StDone = 2'd2
   } rx_state_e;

   localparam logic [7:0] DefaultTerminator = 8'h0D;
   localparam logic [7:0] NullByte          = 8'h00;

endpackage

// File: rtl/rx_edge_detect.sv
// Rising-edge pulse generator: one-cycle pulse when a level goes from 0 to 1.
module rx_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic level_i,
   output logic pulse_o
);

   logic level_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_i;
      end
   end

   assign pulse_o = level_i & ~level_q;

endmodule

// File: rtl/rx_string.sv
// Collects UART bytes into RAM as a null-terminated string and reports
// completion, length and truncation.
module rx_string
   import rx_string_pkg::*;
#(
   parameter logic [7:0]  TERMINATOR = DefaultTerminator,
   parameter int unsigned MAX_LEN    = 32,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  rx_string_ready,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [7:0]            rx_data,
   input  logic                  rx_ready,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   output logic                  wr_en,
   output logic                  rx_string_done,
   output logic [7:0]            rx_length,
   output logic                  rx_overflow
);

   // Count at which only the null still fits.
   localparam logic [7:0] LastCount = 8'(MAX_LEN - 1);

   rx_state_e             state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [7:0]            count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  done_q, done_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]            wr_data_q, wr_data_d;
   logic                  byte_event;

   rx_edge_detect u_rx_edge (
      .clock   (clock),
      .reset   (reset),
      .level_i (rx_ready),
      .pulse_o (byte_event)
   );

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      done_d     = done_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      unique case (state_q)
         StIdle: begin
            done_d     = 1'b0;
            overflow_d = 1'b0;
            if (rx_string_ready) begin
               ptr_d   = start_addr;
               count_d = 8'd0;
               state_d = StWait;
            end
         end
         StWait: begin
            // Abort wins over a byte arriving in the same cycle.
            if (!rx_string_ready) begin
               state_d = StIdle;
            end else if (byte_event) begin
               wr_en_d   = 1'b1;
               wr_addr_d = ptr_q;
               if (rx_data == TERMINATOR) begin
                  wr_data_d = NullByte;
                  state_d   = StDone;
               end else if (count_q == LastCount) begin
                  wr_data_d  = NullByte;
                  overflow_d = 1'b1;
                  state_d    = StDone;
               end else begin
                  wr_data_d = rx_data;
                  ptr_d     = ptr_q + ADDR_WIDTH'(1);
                  count_d   = count_q + 8'd1;
               end
            end
         end
         StDone: begin
            if (!rx_string_ready) begin
               state_d    = StIdle;
               done_d     = 1'b0;
               overflow_d = 1'b0;
            end else begin
               done_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         ptr_q      <= '0;
         count_q    <= 8'd0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         done_q     <= done_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign wr_en          = wr_en_q;
   assign wr_addr        = wr_addr_q;
   assign wr_data        = wr_data_q;
   assign rx_string_done = done_q;
   assign rx_length      = count_q;
   // Overflow is only reported alongside completion.
   assign rx_overflow    = overflow_q & done_q;

endmodule

// File: doc/rx_string.md
Name: rx_string

Overview:
- Receive-side counterpart of the string transmitter.
- Collects bytes from the UART receiver and writes them into a byte-wide RAM from a given start address until a terminator byte arrives.
- Stores 0x00 in place of the terminator, so RAM holds a null-terminated string in the same format the transmitter reads back.
- Reports completion, string length and overflow to the controlling logic.

Parameters:
- TERMINATOR, 8'h0D, byte value that ends a string; never written to RAM.
- MAX_LEN, 32, RAM bytes available per string, including the null; legal range 2..255.
- ADDR_WIDTH, 8, width of start_addr and wr_addr.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx_string_ready  input  1  level; high arms and holds a reception, low returns to idle.
- start_addr  input  ADDR_WIDTH  RAM address of the first character; sampled when armed.
- rx_data  input  8  received byte from the UART receiver; valid while rx_ready is high.
- rx_ready  input  1  UART receiver byte-available level; each rising edge is one new byte.
- wr_addr  output  ADDR_WIDTH  RAM write address.
- wr_data  output  8  RAM write data.
- wr_en  output  1  RAM write strobe, one cycle per write.
- rx_string_done  output  1  level; high when the string is complete in RAM.
- rx_length  output  8  characters stored, excluding the null; valid while rx_string_done is high.
- rx_overflow  output  1  high with rx_string_done if the string was truncated.

Behaviour:
- Reset low, asynchronous: state IDLE; wr_addr=0, wr_data=0, wr_en=0, rx_string_done=0, rx_length=0, rx_overflow=0; internal pointer, count and rx_ready history cleared to 0.
- rx_ready edge detect:
  - One history register tracks rx_ready every cycle, in every state.
  - A byte event is rx_ready=1 with history=0.
  - A level already high when arming is not a byte.
  - Holding rx_ready high for many cycles yields one byte.
- IDLE:
  - Outputs done=0, overflow=0.
  - On rx_string_ready=1: pointer<=start_addr, count<=0, go WAIT.
- WAIT, on a byte event, evaluated in the same cycle:
  - Byte == TERMINATOR: next cycle wr_en=1, wr_addr=pointer, wr_data=0x00; go DONE.
  - Else if count == MAX_LEN-1 (only room for the null): byte discarded; next cycle write 0x00 at pointer; overflow<=1; go DONE.
  - Else: next cycle wr_en=1, wr_addr=pointer, wr_data=byte; pointer+1, count+1; stay WAIT.
- Write latency is exactly one cycle from the byte event to wr_en high. wr_en lasts one cycle. wr_addr/wr_data hold their last values when wr_en=0.
- DONE:
  - rx_string_done=1 from the cycle after the null write.
  - rx_length=count, rx_overflow as latched.
  - Further byte events are ignored, with no writes.
  - Remain until rx_string_ready=0, then IDLE, clearing done and overflow on the next cycle.
- rx_string_ready low in WAIT (abort): go IDLE next cycle; no null written; done stays 0. A byte event in that same cycle is dropped.
- Pointer arithmetic is modulo 2^ADDR_WIDTH; 0xFF+1 wraps to 0x00.
- The terminator as the first byte gives length 0: a single 0x00 is written at start_addr.
- Bytes equal to 0x00 other than the terminator are stored as-is; this is the caller's concern.

Decomposition:
- Shared package: state encoding constants (IDLE, WAIT, DONE), the default terminator 8'h0D and the null byte 8'h00, also used by the string transmitter.
- One natural sub-module: rx_edge_detect, a rising-edge pulse generator with async active-low reset, reusable for tx_done edges.
- Everything else is in one FSM body.

Test Plan:
- Arm with start_addr=0x10, send 0x41,0x44,0x41,0x4D,0x0D. Required: writes 0x10:41, 0x11:44, 0x12:41, 0x13:4D, 0x14:00; done=1; length=4; overflow=0; each wr_en exactly one cycle after its rx_ready edge.
- MAX_LEN=4, send 0x31,0x32,0x33,0x34,0x0D from start 0x00. Required: writes 31,32,33 then 00 at 0x03; 0x34 is never written; overflow=1; length=3; the later 0x0D is ignored.
- start_addr=0xFE, send 0x58,0x59,0x0D. Required: writes 0xFE:58, 0xFF:59, 0x00:00; length=2.
- rx_ready already high when arming, held 20 cycles, then low, then a clean pulse with 0x0D. Required: no write for the held level; a single 00 write at start_addr; length=0.
- After two bytes, drop rx_string_ready. Required: IDLE next cycle; no 00 write; done=0. Then re-arm at 0x20 and send "A",0x0D. Required: writes 0x20:41, 0x21:00.
- Pull reset low mid-string, asynchronously between clock edges. Required: all outputs 0 immediately; no further writes until re-armed after reset is released.
